// File: rtl/dv_test_status_collector.sv
// Multi-channel DV test status collector: latches per-channel verdicts and
// resolves one sticky global pass/fail/timeout end-of-simulation outcome.
module dv_test_status_collector #(
   parameter int unsigned        NumChannels   = 4,
   parameter int unsigned        StatusW       = 16,
   parameter logic [StatusW-1:0] PassCode      = 16'h900d,
   parameter logic [StatusW-1:0] FailCode      = 16'hbaad,
   parameter logic [31:0]        TimeoutCycles = 32'd1000000,
   parameter int unsigned        CntW          = 32
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           start_i,
   input  logic [NumChannels-1:0]         ch_en_i,
   input  logic [NumChannels-1:0]         status_valid_i,
   input  logic [NumChannels*StatusW-1:0] status_i,
   output logic                           done_o,
   output logic                           passed_o,
   output logic                           timeout_o,
   output logic                           error_o,
   output logic [NumChannels-1:0]         ch_passed_o,
   output logic [NumChannels-1:0]         ch_failed_o,
   output logic [CntW-1:0]                cycle_cnt_o
);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   localparam bit ToEn = (TimeoutCycles != 32'd0);
   localparam logic [CntW-1:0] ToLast = CntW'(TimeoutCycles - 32'd1);

   state_e state_q, state_d;

   logic [NumChannels-1:0] mask_q, mask_d;
   logic [NumChannels-1:0] ch_passed_d, ch_failed_d;
   logic [NumChannels-1:0] is_pass, is_fail, is_term;
   logic [NumChannels-1:0] has_vd, dup;
   logic [CntW-1:0]        cnt_d;

   logic done_d, passed_d, timeout_d, error_d;
   logic any_fail, all_pass, tmo_hit;

   // Terminal codes only count on channels armed at start.
   always_comb begin
      is_pass = '0;
      is_fail = '0;
      for (int k = 0; k < NumChannels; k++) begin
         is_pass[k] = status_valid_i[k] & mask_q[k]
                    & (status_i[k*StatusW +: StatusW] == PassCode);
         is_fail[k] = status_valid_i[k] & mask_q[k]
                    & (status_i[k*StatusW +: StatusW] == FailCode);
      end
   end

   assign is_term = is_pass | is_fail;
   assign has_vd  = ch_passed_o | ch_failed_o;
   assign dup     = is_term & has_vd;

   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      cnt_d       = cycle_cnt_o;
      ch_passed_d = ch_passed_o;
      ch_failed_d = ch_failed_o;
      done_d      = done_o;
      passed_d    = passed_o;
      timeout_d   = timeout_o;
      error_d     = error_o;
      any_fail    = 1'b0;
      all_pass    = 1'b0;
      tmo_hit     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               mask_d = ch_en_i;
               cnt_d  = '0;
               if (ch_en_i == '0) begin
                  state_d = StDone;
                  done_d  = 1'b1;
                  error_d = 1'b1;
               end else begin
                  state_d = StRun;
               end
            end
         end

         StRun: begin
            // First verdict per channel wins; repeats only flag an error.
            ch_passed_d = ch_passed_o | (is_pass & ~has_vd);
            ch_failed_d = ch_failed_o | (is_fail & ~has_vd);
            error_d     = error_o | start_i | (|dup);

            any_fail = |(ch_failed_d & mask_q);
            all_pass = ((ch_passed_d & mask_q) == mask_q);
            tmo_hit  = ToEn && (cycle_cnt_o == ToLast);

            if (any_fail) begin
               state_d = StDone;
               done_d  = 1'b1;
            end else if (all_pass) begin
               state_d  = StDone;
               done_d   = 1'b1;
               passed_d = 1'b1;
            end else if (tmo_hit) begin
               state_d   = StDone;
               done_d    = 1'b1;
               timeout_d = 1'b1;
            end else if (cycle_cnt_o != '1) begin
               cnt_d = cycle_cnt_o + CntW'(1);
            end
         end

         StDone: begin
            error_d = error_o | start_i | (|is_term);
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         mask_q      <= '0;
         cycle_cnt_o <= '0;
         ch_passed_o <= '0;
         ch_failed_o <= '0;
         done_o      <= 1'b0;
         passed_o    <= 1'b0;
         timeout_o   <= 1'b0;
         error_o     <= 1'b0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         cycle_cnt_o <= cnt_d;
         ch_passed_o <= ch_passed_d;
         ch_failed_o <= ch_failed_d;
         done_o      <= done_d;
         passed_o    <= passed_d;
         timeout_o   <= timeout_d;
         error_o     <= error_d;
      end
   end

endmodule

// File: tb/tb_dv_test_status_collector.sv
// Bench for dv_test_status_collector: directed scenarios plus randomized
// strobe traffic checked against an outcome-level reference model.
module tb_dv_test_status_collector;

   localparam int N = 4;
   localparam int W = 16;
   localparam int unsigned TMO = 100;
   localparam logic [15:0] PASS = 16'h900d;
   localparam logic [15:0] FAIL = 16'hbaad;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [N-1:0]  ch_en;
   logic [N-1:0]  vld;
   logic [N*W-1:0] st;
   logic          done_o, passed_o, timeout_o, error_o;
   logic [N-1:0]  ch_passed_o, ch_failed_o;
   logic [31:0]   cycle_cnt_o;

   int n_total = 0;
   int n_bad   = 0;

   // Reference model state
   int          m_phase;
   bit          m_done, m_pass, m_tmo, m_err;
   bit [N-1:0]  m_mask, m_cp, m_cf;
   int unsigned m_cnt;

   always #5 clk = ~clk;

   dv_test_status_collector #(
      .NumChannels  (N),
      .StatusW      (W),
      .PassCode     (PASS),
      .FailCode     (FAIL),
      .TimeoutCycles(32'(TMO)),
      .CntW         (32)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .start_i       (start),
      .ch_en_i       (ch_en),
      .status_valid_i(vld),
      .status_i      (st),
      .done_o        (done_o),
      .passed_o      (passed_o),
      .timeout_o     (timeout_o),
      .error_o       (error_o),
      .ch_passed_o   (ch_passed_o),
      .ch_failed_o   (ch_failed_o),
      .cycle_cnt_o   (cycle_cnt_o)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      m_phase = 0;
      m_done  = 0;
      m_pass  = 0;
      m_tmo   = 0;
      m_err   = 0;
      m_mask  = '0;
      m_cp    = '0;
      m_cf    = '0;
      m_cnt   = 0;
   endtask

   // Outcome after one clock edge given the inputs sampled at that edge.
   task automatic model_step(input bit s, input bit [N-1:0] e,
                             input bit [N-1:0] v, input bit [N*W-1:0] d);
      int np, nf, ne;
      bit [15:0] code;
      if (m_phase == 0) begin
         if (s) begin
            m_mask = e;
            m_cnt  = 0;
            if (e == 0) begin
               m_done = 1; m_err = 1; m_phase = 2;
            end else begin
               m_phase = 1;
            end
         end
      end else if (m_phase == 1) begin
         if (s) m_err = 1;
         for (int k = 0; k < N; k++) begin
            code = d[k*W +: W];
            if (m_mask[k] && v[k] && (code == PASS || code == FAIL)) begin
               if (m_cp[k] || m_cf[k]) m_err = 1;
               else if (code == PASS) m_cp[k] = 1;
               else m_cf[k] = 1;
            end
         end
         np = 0; nf = 0; ne = 0;
         for (int k = 0; k < N; k++) begin
            if (m_mask[k]) begin
               ne++;
               np += int'(m_cp[k]);
               nf += int'(m_cf[k]);
            end
         end
         if (nf > 0) begin
            m_done = 1; m_phase = 2;
         end else if (np == ne) begin
            m_done = 1; m_pass = 1; m_phase = 2;
         end else if (m_cnt == TMO - 1) begin
            m_done = 1; m_tmo = 1; m_phase = 2;
         end else begin
            m_cnt++;
         end
      end else begin
         if (s) m_err = 1;
         for (int k = 0; k < N; k++) begin
            code = d[k*W +: W];
            if (m_mask[k] && v[k] && (code == PASS || code == FAIL))
               m_err = 1;
         end
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".done"}, 32'(done_o), 32'(m_done));
      chk({tag, ".pass"}, 32'(passed_o), 32'(m_pass));
      chk({tag, ".tmo"}, 32'(timeout_o), 32'(m_tmo));
      chk({tag, ".err"}, 32'(error_o), 32'(m_err));
      chk({tag, ".cp"}, 32'(ch_passed_o), 32'(m_cp));
      chk({tag, ".cf"}, 32'(ch_failed_o), 32'(m_cf));
      chk({tag, ".cnt"}, cycle_cnt_o, m_cnt);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0;
      ch_en = '0;
      vld   = '0;
      st    = '0;
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic step(input bit s, input bit [N-1:0] e,
                       input bit [N-1:0] v, input bit [N*W-1:0] d);
      @(negedge clk);
      start = s;
      ch_en = e;
      vld   = v;
      st    = d;
      model_step(s, e, v, d);
      @(posedge clk);
      #1;
      start = 1'b0;
      vld   = '0;
   endtask

   task automatic post(input int ch, input logic [15:0] code);
      bit [N*W-1:0] d;
      bit [N-1:0] v;
      d = '0;
      v = '0;
      v[ch] = 1'b1;
      d[ch*W +: W] = code;
      step(0, '0, v, d);
   endtask

   task automatic idle();
      step(0, '0, '0, '0);
   endtask

   initial begin
      bit [N*W-1:0] d;
      bit [N-1:0] v, e;
      bit s;
      int n, rate, r;

      // Reset values and four-channel staggered pass
      do_reset();
      check_model("rst");
      step(1, 4'b1111, '0, '0);
      for (int c = 0; c < 12; c++) begin
         if (c == 5 || c == 7 || c == 9 || c == 11) post((c - 5) / 2, PASS);
         else idle();
         check_model("t1");
      end
      chk("t1.done", 32'(done_o), 32'd1);
      chk("t1.pass", 32'(passed_o), 32'd1);
      chk("t1.cp", 32'(ch_passed_o), 32'hf);
      chk("t1.err", 32'(error_o), 32'd0);
      chk("t1.cnt", cycle_cnt_o, 32'd11);

      // Fail beats pass in the same cycle
      do_reset();
      step(1, 4'b0011, '0, '0);
      d = '0;
      d[0 +: W] = PASS;
      d[W +: W] = FAIL;
      step(0, '0, 4'b0011, d);
      check_model("t2");
      chk("t2.done", 32'(done_o), 32'd1);
      chk("t2.pass", 32'(passed_o), 32'd0);
      chk("t2.cf", 32'(ch_failed_o), 32'b0010);
      chk("t2.cp", 32'(ch_passed_o), 32'b0001);

      // Timeout with no reports
      do_reset();
      step(1, 4'b0001, '0, '0);
      repeat (99) idle();
      chk("t3.early", 32'(done_o), 32'd0);
      idle();
      check_model("t3");
      chk("t3.done", 32'(done_o), 32'd1);
      chk("t3.tmo", 32'(timeout_o), 32'd1);
      chk("t3.cnt", cycle_cnt_o, 32'd99);
      // Pass on the timeout cycle wins
      do_reset();
      step(1, 4'b0001, '0, '0);
      repeat (99) idle();
      post(0, PASS);
      check_model("t3b");
      chk("t3b.pass", 32'(passed_o), 32'd1);
      chk("t3b.tmo", 32'(timeout_o), 32'd0);

      // Disabled channel ignored, late report flagged
      do_reset();
      step(1, 4'b0011, '0, '0);
      post(2, FAIL);
      chk("t4.dis_err", 32'(error_o), 32'd0);
      chk("t4.dis_done", 32'(done_o), 32'd0);
      post(0, PASS);
      post(1, PASS);
      chk("t4.err0", 32'(error_o), 32'd0);
      post(0, PASS);
      check_model("t4");
      chk("t4.late_err", 32'(error_o), 32'd1);
      chk("t4.still_pass", 32'(passed_o), 32'd1);
      step(1, 4'b1111, '0, '0);
      check_model("t4.restart");

      // Duplicate terminal keeps first verdict
      do_reset();
      step(1, 4'b0011, '0, '0);
      post(0, PASS);
      post(0, FAIL);
      check_model("t5");
      chk("t5.err", 32'(error_o), 32'd1);
      chk("t5.cf0", 32'(ch_failed_o[0]), 32'd0);
      chk("t5.run", 32'(done_o), 32'd0);

      // Empty enable mask, then asynchronous reset mid-run
      do_reset();
      step(1, 4'b0000, '0, '0);
      check_model("t6");
      chk("t6.err", 32'(error_o), 32'd1);
      do_reset();
      step(1, 4'b0101, '0, '0);
      post(0, PASS);
      step(1, '0, '0, '0);
      repeat (3) idle();
      check_model("t6.pre");
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      model_clear();
      #1;
      check_model("t6.arst");
      rst_n = 1'b1;

      // Randomized traffic
      for (int t = 0; t < 40; t++) begin
         do_reset();
         e = 4'($urandom_range(0, 15));
         step(1, e, '0, '0);
         check_model("rnd.start");
         n = $urandom_range(20, 130);
         rate = $urandom_range(8, 300);
         for (int i = 0; i < n; i++) begin
            v = '0;
            d = '0;
            for (int k = 0; k < N; k++) begin
               if ($urandom_range(0, rate - 1) == 0) begin
                  v[k] = 1'b1;
                  r = $urandom_range(0, 9);
                  if (r < 4) d[k*W +: W] = PASS;
                  else if (r < 6) d[k*W +: W] = FAIL;
                  else d[k*W +: W] = 16'($urandom);
               end
            end
            s = ($urandom_range(0, 59) == 0);
            step(s, 4'($urandom_range(0, 15)), v, d);
            check_model("rnd");
         end
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
